// File: rtl/ifetch_ctrl_if.sv
// Fetch-control bundle: imem request/response, decode handshake,
// next-PC exchange and backend flush.
interface ifetch_ctrl_if;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        ireq_ready;
    logic        iresp_valid;
    logic [31:0] iresp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [63:0] pc_cur;
    logic [63:0] pc_nxt;
    logic        flush_valid;
    logic [63:0] flush_target;

    modport master (
        output ireq_valid, ireq_addr, instr_valid, instr, pc_cur,
        input  ireq_ready, iresp_valid, iresp_data, instr_ready,
        input  pc_nxt, flush_valid, flush_target
    );

    modport slave (
        input  ireq_valid, ireq_addr, instr_valid, instr, pc_cur,
        output ireq_ready, iresp_valid, iresp_data, instr_ready,
        output pc_nxt, flush_valid, flush_target
    );
endinterface

// File: rtl/ifetch_ctrl.sv
// Fetch control: owns the fetch PC, runs one outstanding imem request
// at a time and hands the fetched word to decode.
module ifetch_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic          clk,
    input  logic          rst,
    ifetch_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        BOOT,
        REQ,
        DROP_REQ,
        WAIT,
        DROP,
        HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] req_addr_q, req_addr_d;
    logic [31:0] instr_q, instr_d;
    logic        ireq_valid_q, ireq_valid_d;
    logic        instr_valid_q, instr_valid_d;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        instr_d    = instr_q;
        unique case (state_q)
            BOOT: state_d = REQ;
            REQ: begin
                if (bus.flush_valid) begin
                    pc_d = bus.flush_target;
                    if (bus.ireq_ready) begin
                        state_d = DROP;
                    end else begin
                        // keep the offered address stable until accepted
                        req_addr_d = pc_q;
                        state_d    = DROP_REQ;
                    end
                end else if (bus.ireq_ready) begin
                    state_d = WAIT;
                end
            end
            DROP_REQ: begin
                if (bus.flush_valid) pc_d = bus.flush_target;
                if (bus.ireq_ready) state_d = DROP;
            end
            WAIT: begin
                if (bus.flush_valid) begin
                    pc_d    = bus.flush_target;
                    state_d = bus.iresp_valid ? REQ : DROP;
                end else if (bus.iresp_valid) begin
                    instr_d = bus.iresp_data;
                    state_d = HOLD;
                end
            end
            DROP: begin
                if (bus.flush_valid) pc_d = bus.flush_target;
                if (bus.iresp_valid) state_d = REQ;
            end
            HOLD: begin
                if (bus.flush_valid) begin
                    pc_d    = bus.flush_target;
                    state_d = REQ;
                end else if (bus.instr_ready) begin
                    pc_d    = bus.pc_nxt;
                    state_d = REQ;
                end
            end
            default: state_d = BOOT;
        endcase
        ireq_valid_d  = (state_d == REQ) || (state_d == DROP_REQ);
        instr_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            req_addr_q    <= RESET_PC;
            instr_q       <= 32'd0;
            ireq_valid_q  <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_addr_q    <= req_addr_d;
            instr_q       <= instr_d;
            ireq_valid_q  <= ireq_valid_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign bus.pc_cur      = pc_q;
    assign bus.ireq_valid  = ireq_valid_q;
    assign bus.ireq_addr   = (state_q == DROP_REQ) ? req_addr_q : pc_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = instr_q;
endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: boot fetch, stalls, redirects,
// flushes in every waiting state and mid-operation reset.
module tb_ifetch_ctrl;
    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    ifetch_ctrl_if bus ();

    ifetch_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        bus.ireq_ready   = 1'b0;
        bus.iresp_valid  = 1'b0;
        bus.iresp_data   = 32'd0;
        bus.instr_ready  = 1'b0;
        bus.pc_nxt       = 64'd0;
        bus.flush_valid  = 1'b0;
        bus.flush_target = 64'd0;
        tick();
        tick();
        chk("rst_ireq_valid", {63'd0, bus.ireq_valid}, 64'd0);
        chk("rst_instr_valid", {63'd0, bus.instr_valid}, 64'd0);
        chk("rst_ireq_addr", bus.ireq_addr, RST_PC);
        chk("rst_pc_cur", bus.pc_cur, RST_PC);
        chk("rst_instr", {32'd0, bus.instr}, 64'd0);

        // boot fetch with ready memory and 1-cycle response
        rst = 1'b0;
        bus.ireq_ready = 1'b1;
        tick();
        chk("boot_req_valid", {63'd0, bus.ireq_valid}, 64'd1);
        chk("boot_req_addr", bus.ireq_addr, 64'h8000_0000);
        tick();
        bus.ireq_ready = 1'b0;
        chk("boot_wait_noreq", {63'd0, bus.ireq_valid}, 64'd0);
        bus.iresp_valid = 1'b1;
        bus.iresp_data  = 32'h0000_0013;
        tick();
        bus.iresp_valid = 1'b0;
        chk("boot_instr_valid", {63'd0, bus.instr_valid}, 64'd1);
        chk("boot_instr", {32'd0, bus.instr}, 64'h13);
        chk("boot_pc_cur", bus.pc_cur, 64'h8000_0000);

        // decode stalls 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", {63'd0, bus.instr_valid}, 64'd1);
            chk("stall_instr", {32'd0, bus.instr}, 64'h13);
            chk("stall_pc", bus.pc_cur, 64'h8000_0000);
            chk("stall_noreq", {63'd0, bus.ireq_valid}, 64'd0);
        end

        // sequential accept
        bus.instr_ready = 1'b1;
        bus.pc_nxt      = 64'h8000_0004;
        tick();
        bus.instr_ready = 1'b0;
        chk("seq_instr_valid", {63'd0, bus.instr_valid}, 64'd0);
        chk("seq_req_valid", {63'd0, bus.ireq_valid}, 64'd1);
        chk("seq_req_addr", bus.ireq_addr, 64'h8000_0004);

        // redirect accept
        bus.ireq_ready = 1'b1;
        tick();
        bus.ireq_ready  = 1'b0;
        bus.iresp_valid = 1'b1;
        bus.iresp_data  = 32'h0010_0093;
        tick();
        bus.iresp_valid = 1'b0;
        chk("redir_instr", {32'd0, bus.instr}, 64'h0010_0093);
        chk("redir_pc_cur", bus.pc_cur, 64'h8000_0004);
        bus.instr_ready = 1'b1;
        bus.pc_nxt      = 64'h8000_1000;
        tick();
        bus.instr_ready = 1'b0;
        chk("redir_req_addr", bus.ireq_addr, 64'h8000_1000);

        // flush while waiting; late response must be dropped
        bus.ireq_ready = 1'b1;
        tick();
        bus.ireq_ready   = 1'b0;
        bus.flush_valid  = 1'b1;
        bus.flush_target = 64'h8000_2000;
        tick();
        bus.flush_valid = 1'b0;
        chk("wflush_noreq", {63'd0, bus.ireq_valid}, 64'd0);
        chk("wflush_pc", bus.pc_cur, 64'h8000_2000);
        tick();
        tick();
        chk("wflush_drop_iv", {63'd0, bus.instr_valid}, 64'd0);
        bus.iresp_valid = 1'b1;
        bus.iresp_data  = 32'hDEAD_BEEF;
        tick();
        bus.iresp_valid = 1'b0;
        chk("wflush_no_instr", {63'd0, bus.instr_valid}, 64'd0);
        chk("wflush_req_valid", {63'd0, bus.ireq_valid}, 64'd1);
        chk("wflush_req_addr", bus.ireq_addr, 64'h8000_2000);
        tick();
        chk("wflush_still_iv0", {63'd0, bus.instr_valid}, 64'd0);

        // flush while request is stalled by memory
        bus.flush_valid  = 1'b1;
        bus.flush_target = 64'h9000_0000;
        tick();
        bus.flush_valid = 1'b0;
        chk("rflush_req_valid", {63'd0, bus.ireq_valid}, 64'd1);
        chk("rflush_addr_hold", bus.ireq_addr, 64'h8000_2000);
        chk("rflush_pc", bus.pc_cur, 64'h9000_0000);
        tick();
        chk("rflush_addr_hold2", bus.ireq_addr, 64'h8000_2000);
        tick();
        chk("rflush_addr_hold3", bus.ireq_addr, 64'h8000_2000);
        bus.ireq_ready = 1'b1;
        tick();
        bus.ireq_ready = 1'b0;
        chk("rflush_drop_noreq", {63'd0, bus.ireq_valid}, 64'd0);
        bus.iresp_valid = 1'b1;
        bus.iresp_data  = 32'h1111_1111;
        tick();
        bus.iresp_valid = 1'b0;
        chk("rflush_no_instr", {63'd0, bus.instr_valid}, 64'd0);
        chk("rflush_req_addr", bus.ireq_addr, 64'h9000_0000);

        // flush together with response in WAIT
        bus.ireq_ready = 1'b1;
        tick();
        bus.ireq_ready   = 1'b0;
        bus.iresp_valid  = 1'b1;
        bus.iresp_data   = 32'h2222_2222;
        bus.flush_valid  = 1'b1;
        bus.flush_target = 64'hA000_0000;
        tick();
        bus.iresp_valid = 1'b0;
        bus.flush_valid = 1'b0;
        chk("wrace_no_instr", {63'd0, bus.instr_valid}, 64'd0);
        chk("wrace_req_valid", {63'd0, bus.ireq_valid}, 64'd1);
        chk("wrace_req_addr", bus.ireq_addr, 64'hA000_0000);

        // flush together with decode accept in HOLD
        bus.ireq_ready = 1'b1;
        tick();
        bus.ireq_ready  = 1'b0;
        bus.iresp_valid = 1'b1;
        bus.iresp_data  = 32'h3333_3333;
        tick();
        bus.iresp_valid = 1'b0;
        chk("hrace_instr", {32'd0, bus.instr}, 64'h3333_3333);
        chk("hrace_pc_cur", bus.pc_cur, 64'hA000_0000);
        bus.instr_ready  = 1'b1;
        bus.pc_nxt       = 64'hA000_0004;
        bus.flush_valid  = 1'b1;
        bus.flush_target = 64'hB000_0000;
        tick();
        bus.instr_ready = 1'b0;
        bus.flush_valid = 1'b0;
        chk("hrace_iv", {63'd0, bus.instr_valid}, 64'd0);
        chk("hrace_req_addr", bus.ireq_addr, 64'hB000_0000);

        // asynchronous reset mid-request
        bus.ireq_ready = 1'b1;
        tick();
        bus.ireq_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_ireq_valid", {63'd0, bus.ireq_valid}, 64'd0);
        chk("mrst_pc_cur", bus.pc_cur, RST_PC);
        chk("mrst_ireq_addr", bus.ireq_addr, RST_PC);
        chk("mrst_instr", {32'd0, bus.instr}, 64'd0);
        tick();
        rst = 1'b0;
        bus.ireq_ready = 1'b1;
        tick();
        chk("mrst_reboot_addr", bus.ireq_addr, RST_PC);
        chk("mrst_reboot_valid", {63'd0, bus.ireq_valid}, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
